// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared state type, constants and sign helper for div32_unit
package div_pkg;

    localparam int DIV_W     = 32;
    localparam int DIV_ITERS = 32;
    localparam int CNT_W     = $clog2(DIV_ITERS);

    localparam logic [CNT_W-1:0] LAST_ITER    = CNT_W'(DIV_ITERS - 1);
    localparam logic [DIV_W-1:0] DIV_ZERO_QUO = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        FIXUP = 2'd2
    } div_state_t;

    // Two's-complement negate when neg is set; used both to take magnitudes and to restore signs.
    function automatic logic [DIV_W-1:0] apply_sign(input logic [DIV_W-1:0] v, input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring-division iteration
module div_step
    import div_pkg::*;
(
    input  logic [DIV_W-1:0] rem,
    input  logic [DIV_W-1:0] quo,
    input  logic [DIV_W-1:0] divisor,
    output logic [DIV_W-1:0] rem_next,
    output logic [DIV_W-1:0] quo_next
);

    logic [DIV_W:0]   shifted;
    logic [DIV_W+1:0] trial;
    logic             borrow;
    logic             unused_trial_bit;

    assign shifted = {rem, quo[DIV_W-1]};
    assign trial   = {1'b0, shifted} - {2'b00, divisor};
    assign borrow  = trial[DIV_W+1];

    // A kept difference is always below the divisor, so it fits back into DIV_W bits.
    assign rem_next         = borrow ? shifted[DIV_W-1:0] : trial[DIV_W-1:0];
    assign quo_next         = {quo[DIV_W-2:0], ~borrow};
    assign unused_trial_bit = trial[DIV_W];

endmodule

// File: rtl/div32_unit.sv
// rtl/div32_unit.sv - multi-cycle 32-bit divider for HI/LO; DIV_SIGNED_EN enables signed DIV
module div32_unit
    import div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             Start,
    input  logic             Signed,
    input  logic             Cancel,
    input  logic [WIDTH-1:0] Dividend,
    input  logic [WIDTH-1:0] Divisor,
    output logic             Busy,
    output logic             Done,
    output logic             DivZero,
    output logic [WIDTH-1:0] Quotient,
    output logic [WIDTH-1:0] Remainder
);

    div_state_t       state, state_next;
    logic [CNT_W-1:0] count;
    logic [DIV_W-1:0] rem_r, quo_r, dsr_r;
    logic [DIV_W-1:0] rem_step, quo_step;
    logic             dz_r;
    logic             accept;
    logic             zero_dsr;
    logic [DIV_W-1:0] dvd_mag, dsr_mag, quo_fix, rem_fix;

    assign zero_dsr = (Divisor == '0);

    div_step u_step (
        .rem      (rem_r),
        .quo      (quo_r),
        .divisor  (dsr_r),
        .rem_next (rem_step),
        .quo_next (quo_step)
    );

`ifdef DIV_SIGNED_EN
    logic dvd_neg, dsr_neg, neg_q, neg_r;

    assign dvd_neg = Signed & Dividend[DIV_W-1];
    assign dsr_neg = Signed & Divisor[DIV_W-1];
    assign dvd_mag = apply_sign(Dividend, dvd_neg);
    assign dsr_mag = apply_sign(Divisor, dsr_neg);

    // A zero-divisor result is returned raw, so its sign flags stay clear.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (accept) begin
            neg_q <= ~zero_dsr & (dvd_neg ^ dsr_neg);
            neg_r <= ~zero_dsr & dvd_neg;
        end
    end

    assign quo_fix = apply_sign(quo_r, neg_q);
    assign rem_fix = apply_sign(rem_r, neg_r);
`else
    logic unused_signed;

    assign unused_signed = Signed;
    assign dvd_mag       = Dividend;
    assign dsr_mag       = Divisor;
    assign quo_fix       = quo_r;
    assign rem_fix       = rem_r;
`endif

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (Cancel) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (Start) state_next = zero_dsr ? FIXUP : CALC;
                CALC:    if (count == LAST_ITER) state_next = FIXUP;
                FIXUP:   state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        Busy   = 1'b0;
        accept = 1'b0;
        Busy   = (state != IDLE);
        accept = (state == IDLE) && Start && !Cancel;
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            count     <= '0;
            rem_r     <= '0;
            quo_r     <= '0;
            dsr_r     <= '0;
            dz_r      <= 1'b0;
            Done      <= 1'b0;
            DivZero   <= 1'b0;
            Quotient  <= '0;
            Remainder <= '0;
        end else begin
            Done <= 1'b0;
            if (accept) begin
                count <= '0;
                dsr_r <= dsr_mag;
                dz_r  <= zero_dsr;
                if (zero_dsr) begin
                    quo_r <= DIV_ZERO_QUO;
                    rem_r <= Dividend;
                end else begin
                    quo_r <= dvd_mag;
                    rem_r <= '0;
                end
            end else if (state == CALC && !Cancel) begin
                rem_r <= rem_step;
                quo_r <= quo_step;
                count <= count + 1'b1;
            end else if (state == FIXUP && !Cancel) begin
                Quotient  <= quo_fix;
                Remainder <= rem_fix;
                DivZero   <= dz_r;
                Done      <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_div32_unit.sv
// tb/tb_div32_unit.sv - self-checking bench for div32_unit with a behavioural divide model
module tb_div32_unit;

`ifdef DIV_SIGNED_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif

    logic        Clk, Rst_n, Start, Signed, Cancel;
    logic [31:0] Dividend, Divisor;
    logic        Busy, Done, DivZero;
    logic [31:0] Quotient, Remainder;

    int checks   = 0;
    int failures = 0;

    int cur, done_cyc, done_cnt, busy_lo, busy_hi, busy_cnt;

    div32_unit #(.WIDTH(32)) dut (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .Start     (Start),
        .Signed    (Signed),
        .Cancel    (Cancel),
        .Dividend  (Dividend),
        .Divisor   (Divisor),
        .Busy      (Busy),
        .Done      (Done),
        .DivZero   (DivZero),
        .Quotient  (Quotient),
        .Remainder (Remainder)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic void ref_div(input logic [31:0] a, input logic [31:0] b, input bit s,
                                    output logic [31:0] q, output logic [31:0] r, output bit dz);
        longint sa, sb;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF; r = a; dz = 1'b1;
        end else if (s && SIGNED_EN) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = 32'(sa / sb);
            r  = 32'(sa % sb);
            dz = 1'b0;
        end else begin
            q = a / b; r = a % b; dz = 1'b0;
        end
    endfunction

    task automatic sample_cycle();
        @(negedge Clk);
        if (Busy) begin
            busy_cnt++;
            if (busy_lo < 0) busy_lo = cur;
            busy_hi = cur;
        end
        if (Done) begin
            done_cnt++;
            if (done_cyc < 0) done_cyc = cur;
        end
    endtask

    task automatic launch(input logic [31:0] a, input logic [31:0] b, input bit s, input bit now);
        if (!now) begin @(posedge Clk); #1; end
        Dividend = a; Divisor = b; Signed = s; Start = 1'b1;
        cur = 0; done_cyc = -1; done_cnt = 0; busy_lo = -1; busy_hi = -1; busy_cnt = 0;
        @(posedge Clk); #1;
        Start = 1'b0;
        cur = 1;
    endtask

    task automatic run_to(input int n);
        while (cur < n) begin
            sample_cycle();
            @(posedge Clk); #1;
            cur++;
        end
    endtask

    task automatic run_until_done(input int limit);
        forever begin
            sample_cycle();
            if (done_cyc >= 0 || cur >= limit) break;
            @(posedge Clk); #1;
            cur++;
        end
    endtask

    task automatic test_reset();
        checks++; if (Busy !== 1'b0)        begin failures++; $display("FAIL reset_busy: got %b want 0", Busy); end
        checks++; if (Done !== 1'b0)        begin failures++; $display("FAIL reset_done: got %b want 0", Done); end
        checks++; if (DivZero !== 1'b0)     begin failures++; $display("FAIL reset_divzero: got %b want 0", DivZero); end
        checks++; if (Quotient !== 32'd0)   begin failures++; $display("FAIL reset_quotient: got %h want 0", Quotient); end
        checks++; if (Remainder !== 32'd0)  begin failures++; $display("FAIL reset_remainder: got %h want 0", Remainder); end
    endtask

    task automatic test_unsigned_latency();
        launch(32'd100, 32'd7, 1'b0, 1'b0);
        run_until_done(60);
        checks++; if (done_cyc !== 34) begin failures++; $display("FAIL u_done_cycle: got %0d want 34", done_cyc); end
        checks++; if (busy_lo !== 1 || busy_hi !== 33 || busy_cnt !== 33)
            begin failures++; $display("FAIL u_busy_window: got %0d..%0d (%0d) want 1..33 (33)", busy_lo, busy_hi, busy_cnt); end
        checks++; if (Quotient !== 32'd14 || Remainder !== 32'd2 || DivZero !== 1'b0)
            begin failures++; $display("FAIL u_100_7: got q=%h r=%h dz=%b want q=e r=2 dz=0", Quotient, Remainder, DivZero); end
        @(posedge Clk); #1;
        checks++; if (Done !== 1'b0 || Quotient !== 32'd14)
            begin failures++; $display("FAIL u_hold: got done=%b q=%h want done=0 q=e", Done, Quotient); end
    endtask

    task automatic test_signed_small();
        logic [31:0] eq, er;
        eq = SIGNED_EN ? 32'hFFFF_FFFD : 32'h7FFF_FFFC;
        er = SIGNED_EN ? 32'hFFFF_FFFF : 32'h0000_0001;
        launch(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0);
        run_until_done(60);
        checks++; if (done_cyc !== 34 || Quotient !== eq || Remainder !== er || DivZero !== 1'b0)
            begin failures++; $display("FAIL s_m7_2: got cyc=%0d q=%h r=%h dz=%b want cyc=34 q=%h r=%h dz=0",
                                       done_cyc, Quotient, Remainder, DivZero, eq, er); end
    endtask

    task automatic test_div_zero();
        launch(32'h1234, 32'd0, 1'b1, 1'b0);
        run_until_done(60);
        checks++; if (done_cyc !== 2 || busy_lo !== 1 || busy_hi !== 1)
            begin failures++; $display("FAIL dz_timing: got done=%0d busy=%0d..%0d want done=2 busy=1..1", done_cyc, busy_lo, busy_hi); end
        checks++; if (Quotient !== 32'hFFFF_FFFF || Remainder !== 32'h1234 || DivZero !== 1'b1)
            begin failures++; $display("FAIL dz_result: got q=%h r=%h dz=%b want q=ffffffff r=1234 dz=1", Quotient, Remainder, DivZero); end
        launch(32'd50, 32'd5, 1'b0, 1'b0);
        run_until_done(60);
        checks++; if (DivZero !== 1'b0 || Quotient !== 32'd10 || Remainder !== 32'd0)
            begin failures++; $display("FAIL dz_clear: got q=%h r=%h dz=%b want q=a r=0 dz=0", Quotient, Remainder, DivZero); end
    endtask

    task automatic test_overflow();
        logic [31:0] eq, er;
        eq = SIGNED_EN ? 32'h8000_0000 : 32'h0000_0000;
        er = SIGNED_EN ? 32'h0000_0000 : 32'h8000_0000;
        launch(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0);
        run_until_done(60);
        checks++; if (Quotient !== eq || Remainder !== er || DivZero !== 1'b0 || done_cyc !== 34)
            begin failures++; $display("FAIL overflow: got q=%h r=%h dz=%b cyc=%0d want q=%h r=%h dz=0 cyc=34",
                                       Quotient, Remainder, DivZero, done_cyc, eq, er); end
    endtask

    task automatic test_random();
        logic [31:0] a, b, eq, er;
        bit s, edz;
        int kind;
        for (int i = 0; i < 30; i++) begin
            a    = $urandom;
            kind = $urandom_range(0, 5);
            case (kind)
                0:       b = 32'd0;
                1:       b = $urandom_range(1, 15);
                2:       b = -$urandom_range(1, 15);
                3:       b = $urandom >> $urandom_range(0, 31);
                default: b = $urandom;
            endcase
            s = 1'($urandom_range(0, 1));
            ref_div(a, b, s, eq, er, edz);
            launch(a, b, s, 1'b0);
            run_until_done(60);
            checks++;
            if (Quotient !== eq || Remainder !== er || DivZero !== edz || done_cyc !== ((b == 0) ? 2 : 34) || done_cnt !== 1)
                begin failures++; $display("FAIL rand_%0d: a=%h b=%h s=%b got q=%h r=%h dz=%b cyc=%0d want q=%h r=%h dz=%b",
                                           i, a, b, s, Quotient, Remainder, DivZero, done_cyc, eq, er, edz); end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] eq, er;
        bit edz;
        launch(32'd1000, 32'd9, 1'b0, 1'b0);
        run_until_done(60);
        ref_div(32'hFFFF_FF00, 32'd3, 1'b1, eq, er, edz);
        launch(32'hFFFF_FF00, 32'd3, 1'b1, 1'b1);
        run_until_done(60);
        checks++; if (done_cyc !== 34 || Quotient !== eq || Remainder !== er || DivZero !== edz)
            begin failures++; $display("FAIL b2b: got cyc=%0d q=%h r=%h want cyc=34 q=%h r=%h", done_cyc, Quotient, Remainder, eq, er); end
    endtask

    task automatic test_cancel();
        logic [31:0] pq, pr, eq, er;
        logic pdz;
        bit edz;
        pq = Quotient; pr = Remainder; pdz = DivZero;
        launch(32'd12345, 32'd11, 1'b0, 1'b0);
        run_to(10);
        Cancel = 1'b1;
        run_to(11);
        Cancel = 1'b0;
        @(negedge Clk);
        checks++; if (Busy !== 1'b0 || busy_hi !== 10 || done_cnt !== 0 || Done !== 1'b0)
            begin failures++; $display("FAIL cancel_idle: got busy=%b last_busy=%0d dones=%0d want busy=0 last_busy=10 dones=0", Busy, busy_hi, done_cnt); end
        checks++; if (Quotient !== pq || Remainder !== pr || DivZero !== pdz)
            begin failures++; $display("FAIL cancel_hold: got q=%h r=%h want q=%h r=%h", Quotient, Remainder, pq, pr); end
        ref_div(32'd999, 32'd37, 1'b0, eq, er, edz);
        launch(32'd999, 32'd37, 1'b0, 1'b1);
        run_until_done(60);
        checks++; if (done_cyc !== 34 || Quotient !== eq || Remainder !== er || DivZero !== edz)
            begin failures++; $display("FAIL cancel_restart: got cyc=%0d q=%h r=%h want cyc=34 q=%h r=%h", done_cyc, Quotient, Remainder, eq, er); end
        // Cancel arriving in the final (fixup) cycle must still swallow the result.
        pq = Quotient; pr = Remainder;
        launch(32'd77, 32'd4, 1'b0, 1'b0);
        run_to(33);
        Cancel = 1'b1;
        run_to(34);
        Cancel = 1'b0;
        run_to(40);
        checks++; if (done_cnt !== 0 || Quotient !== pq || Remainder !== pr)
            begin failures++; $display("FAIL cancel_fixup: got dones=%0d q=%h r=%h want dones=0 q=%h r=%h", done_cnt, Quotient, Remainder, pq, pr); end
    endtask

    task automatic test_start_ignored();
        logic [31:0] eq, er;
        bit edz;
        ref_div(32'd5000, 32'd13, 1'b0, eq, er, edz);
        launch(32'd5000, 32'd13, 1'b0, 1'b0);
        run_to(5);
        Dividend = 32'd8; Divisor = 32'd3; Start = 1'b1;
        run_to(6);
        Start = 1'b0;
        run_until_done(60);
        checks++; if (done_cyc !== 34 || done_cnt !== 1 || Quotient !== eq || Remainder !== er)
            begin failures++; $display("FAIL start_busy: got cyc=%0d q=%h r=%h want cyc=34 q=%h r=%h", done_cyc, Quotient, Remainder, eq, er); end
    endtask

    task automatic test_reset_mid();
        launch(32'd4242, 32'd5, 1'b0, 1'b0);
        run_to(20);
        #2 Rst_n = 1'b0;
        #1;
        checks++; if (Busy !== 1'b0 || Done !== 1'b0 || DivZero !== 1'b0 || Quotient !== 32'd0 || Remainder !== 32'd0)
            begin failures++; $display("FAIL reset_mid: got busy=%b done=%b dz=%b q=%h r=%h want all 0", Busy, Done, DivZero, Quotient, Remainder); end
        @(posedge Clk); #1;
        Rst_n = 1'b1;
        cur = 21; done_cnt = 0; busy_cnt = 0;
        run_to(60);
        checks++; if (done_cnt !== 0 || busy_cnt !== 0)
            begin failures++; $display("FAIL reset_no_done: got dones=%0d busy_cycles=%0d want 0 0", done_cnt, busy_cnt); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        Rst_n = 1'b0; Start = 1'b0; Signed = 1'b0; Cancel = 1'b0;
        Dividend = '0; Divisor = '0;
        cur = 0; done_cyc = -1; done_cnt = 0; busy_lo = -1; busy_hi = -1; busy_cnt = 0;
        #22;
        test_reset();
        @(negedge Clk);
        Rst_n = 1'b1;
        test_unsigned_latency();
        test_signed_small();
        test_div_zero();
        test_overflow();
        test_random();
        test_back_to_back();
        test_cancel();
        test_start_ignored();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
